// File: rtl/dut_stim_gen_if.sv
// Command/status bundle between the UART command receiver and the DUT stimulus generator.
// Latency: wires only, no registers.
// Backpressure: none; start is a sticky level and only its rising edge is acted on.
interface dut_stim_gen_if #(
    parameter int LEN_W = 12
);
    logic             start;
    logic [15:0]      cmd_word;
    logic             abort;
    logic             dut_clk;
    logic             dut_din;
    logic             dut_en;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_cnt;

    // master: command receiver side; slave: stimulus generator side
    modport master (
        output start, cmd_word, abort,
        input  dut_clk, dut_din, dut_en, busy, done, bit_cnt
    );

    modport slave (
        input  start, cmd_word, abort,
        output dut_clk, dut_din, dut_en, busy, done, bit_cnt
    );
endinterface

// File: rtl/dut_stim_gen.sv
// Gated, divided serial clock + pattern generator for the DUT; pattern 3 is PRBS7 when STIM_PRBS_EN is defined.
// Latency: busy/dut_en/first bit one cycle after the start edge; RUN lasts 2*N*(1<<sel) cycles, then a one-cycle done.
// Backpressure: none; start edges outside IDLE are dropped, abort returns to IDLE on the next cycle.
module dut_stim_gen #(
    parameter int LEN_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    dut_stim_gen_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic             start_q;
    logic [LEN_W-1:0] len_q;
    logic [1:0]       sel_q;
    logic [1:0]       pat_q;
    logic [2:0]       div_cnt;
    logic [LEN_W-1:0] bit_cnt_q;
    logic             dut_clk_q;
    logic             dut_din_q;
    logic             dut_en_q;
    logic             busy_q;
    logic             done_q;

    logic             start_edge;
    logic [LEN_W-1:0] cmd_len;
    logic [2:0]       half_m1;
    logic             half_tick;
    logic             first_din;
    logic             next_din;

    assign start_edge = bus.start & ~start_q;
    assign cmd_len    = LEN_W'(bus.cmd_word[15:4]);
    assign half_m1    = 3'((4'd1 << sel_q) - 4'd1);
    assign half_tick  = (div_cnt == half_m1);

    // Bit 0 of each pattern, driven straight from the command word on the capture cycle
    always_comb begin
        first_din = 1'b0;
        case (bus.cmd_word[1:0])
            2'd1:    first_din = 1'b1;
`ifdef STIM_PRBS_EN
            2'd3:    first_din = 1'b1;
`endif
            default: first_din = 1'b0;
        endcase
    end

`ifdef STIM_PRBS_EN
    logic [6:0] lfsr;
    logic       pg_load;
    logic       pg_adv;

    assign pg_load = (state == S_IDLE) && start_edge;
    assign pg_adv  = (state == S_RUN) && !bus.abort && half_tick && dut_clk_q
                     && (bit_cnt_q != len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h7F;
        end else if (pg_load) begin
            lfsr <= 7'h7F;
        end else if (pg_adv) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end
`endif

    // Next bit after a falling dut_clk; the LFSR tap lfsr[5] becomes the new lfsr[6]
    always_comb begin
        next_din = 1'b0;
        case (pat_q)
            2'd1: next_din = 1'b1;
            2'd2: next_din = ~dut_din_q;
`ifdef STIM_PRBS_EN
            2'd3: next_din = lfsr[5];
`else
            2'd3: next_din = ~dut_din_q;
`endif
            default: next_din = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            len_q     <= '0;
            sel_q     <= 2'd0;
            pat_q     <= 2'd0;
            div_cnt   <= 3'd0;
            bit_cnt_q <= '0;
            dut_clk_q <= 1'b0;
            dut_din_q <= 1'b0;
            dut_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q <= bus.start;
            case (state)
                S_IDLE: begin
                    dut_clk_q <= 1'b0;
                    dut_din_q <= 1'b0;
                    dut_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    div_cnt   <= 3'd0;
                    if (start_edge) begin
                        len_q     <= cmd_len;
                        sel_q     <= bus.cmd_word[3:2];
                        pat_q     <= bus.cmd_word[1:0];
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        if (cmd_len == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            dut_en_q  <= 1'b1;
                            dut_din_q <= first_din;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.abort) begin
                        // bit_cnt deliberately keeps the count reached so far
                        state     <= S_IDLE;
                        dut_clk_q <= 1'b0;
                        dut_din_q <= 1'b0;
                        dut_en_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        div_cnt   <= 3'd0;
                    end else if (half_tick) begin
                        div_cnt   <= 3'd0;
                        dut_clk_q <= ~dut_clk_q;
                        if (!dut_clk_q) begin
                            bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                        end else if (bit_cnt_q == len_q) begin
                            state     <= S_DONE;
                            dut_en_q  <= 1'b0;
                            dut_din_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            dut_din_q <= next_din;
                        end
                    end else begin
                        div_cnt <= div_cnt + 3'd1;
                    end
                end

                S_DONE: begin
                    // abort here lands in the same place as a normal exit
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_clk = dut_clk_q;
    assign bus.dut_din = dut_din_q;
    assign bus.dut_en  = dut_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_cnt = bit_cnt_q;

    a_done_single: assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);
    a_en_busy:     assert property (@(posedge clk) disable iff (rst) dut_en_q |-> busy_q);
    a_clk_gated:   assert property (@(posedge clk) disable iff (rst) dut_clk_q |-> dut_en_q);

endmodule

// File: doc/dut_stim_gen.md
# dut_stim_gen

Stimulus generator that sits directly downstream of the UART command receiver. It consumes the assembled 16-bit command word and the receiver's sticky `start` level. On each start edge it drives a gated, divided serial clock plus a serial data pattern into the 22nm device under test (DUT). The pattern type, clock ratio and bit count all come from the command word.

## Interface
- `LEN_W`, default 12: width of the bit-count field, taken from `cmd_word[15:4]`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  sticky level from the receiver; only a 0→1 transition is acted on.
- `cmd_word`  in  16  command fields:
  - [15:4] bit count N
  - [3:2] clock select
  - [1:0] pattern select
- `abort`  in  1  synchronous abort, active-high.
- `dut_clk`  out  1  divided DUT clock, registered, idle low.
- `dut_din`  out  1  serial data to the DUT, registered.
- `dut_en`  out  1  frame enable, high while bits are being shifted.
- `busy`  out  1  high from the capture cycle through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `bit_cnt`  out  LEN_W  number of rising `dut_clk` edges issued in the current or most recent frame.

## Operation
- Start detection:
  - A `start_q` flop is registered every cycle.
  - A start edge is `start & ~start_q`, evaluated only in IDLE.
  - Start edges seen while `busy` is high are ignored.
- On the capture cycle the block latches `len=cmd_word[15:4]`, `sel=cmd_word[3:2]` and `pat=cmd_word[1:0]` into shadow registers. A later change of `cmd_word` does not affect a running frame.
- State machine IDLE → RUN → DONE → IDLE:
  - **IDLE**: all outputs low. On a start edge: capture, set `busy`, clear `bit_cnt`, and load the pattern generator.
    - If `len==0`, go to DONE.
    - Otherwise go to RUN with `dut_en=1`, `dut_clk=0` and `dut_din` set to bit 0.
  - **RUN**:
    - Half-period H = 1<<sel clk cycles, so H is 1, 2, 4 or 8 and the `dut_clk` period is 2, 4, 8 or 16 clk.
    - Divider counter `div_cnt` (3 bits) increments each cycle. When `div_cnt==H-1` it resets to 0 and `dut_clk` toggles.
    - On a 0→1 toggle: `bit_cnt` increments.
    - On a 1→0 toggle: if `bit_cnt==len`, drop `dut_en` and `dut_din` and go to DONE; otherwise advance to the next pattern bit.
  - **DONE**: `done=1` for exactly one cycle, `busy` stays high, then go to IDLE.
- Patterns, indexed by `pat`:
  - 0: all zero.
  - 1: all one.
  - 2: alternating, bit 0 = 0.
  - 3: PRBS7 when enabled (see Configuration). Seed 7'h7F, output `lfsr[6]`, next state `{lfsr[5:0], lfsr[6]^lfsr[5]}`.
- Abort:
  - Asserted in RUN or DONE: next cycle is IDLE with `dut_clk`, `dut_en`, `dut_din` and `busy` all 0, and no `done` pulse.
  - `bit_cnt` holds its value at the moment of abort.
  - Ignored in IDLE.
- `abort` and a start edge in the same IDLE cycle: the start is taken.

## Timing
- Reset values: state=IDLE, `dut_clk`=0, `dut_din`=0, `dut_en`=0, `busy`=0, `done`=0, `bit_cnt`=0, `start_q`=0, `div_cnt`=0, `lfsr`=7'h7F.
- Reset mid-frame: the frame is abandoned immediately; no `done` pulse.
- Capture latency: the start edge is seen at cycle C. `busy`, `dut_en` and the first `dut_din` are high from C+1.
- RUN lasts exactly 2·N·H cycles. `done` is high in the cycle after `dut_en` falls.
- For `len==0`, `done` is high at C+1 and `busy` is high only at C+1.
- Data changes only on falling `dut_clk` (or at RUN entry), so the DUT samples on the rising edge with H clk of setup.
- The maximum N of 4095 completes without `bit_cnt` wrap.
- Back-to-back frames: a new start edge is accepted no earlier than the first IDLE cycle after DONE. Because `start` is sticky, the receiver must drop it and re-raise it.

## Configuration
- `STIM_PRBS_EN` defined: pattern 3 is PRBS7 as specified and the LFSR is implemented.
- `STIM_PRBS_EN` undefined: no LFSR logic; pattern 3 behaves identically to pattern 2 (alternating).

## Test plan
- Reset, then `cmd_word`=16'h0041 (N=4, /2, ones) and raise `start` → 4 `dut_clk` pulses of period 2 clk, `dut_din`=1 throughout, `dut_en` high for 8 cycles, `done` 1 cycle later, `bit_cnt`=4.
- `cmd_word`=16'h00AE (N=10, /16, alternating) → `dut_din` at successive rising edges is 0,1,0,1,…; RUN lasts 160 cycles; `bit_cnt`=10.
- `STIM_PRBS_EN`, `cmd_word`=16'h0083 (N=8, /2, PRBS) → rising-edge bits 1,1,1,1,1,1,1,0. Without the macro the same command yields 0,1,0,1,0,1,0,1.
- `cmd_word`=16'h0001 (N=0) → `done` and `busy` both high at C+1 only; `dut_clk` never toggles.
- N=16 frame with `abort` pulsed after the 5th rising edge → outputs low next cycle, no `done`, `bit_cnt`=5. Asserting `rst` mid-frame instead → all outputs 0 immediately.
- Toggle `start` 1→0→1 while `busy` → ignored. Change `cmd_word` mid-frame → current frame unaffected. New start edge after DONE → second frame runs.
